// File: rtl/spi_slave_rx.sv
// SPI receive-only slave: synchronizes the serial pins into the clk domain,
// assembles MSB-first frames of WIDTH bits and hands them out on a valid/ready port.
module spi_slave_rx #(
  parameter int WIDTH             = 16,
  parameter bit CPOL0_SAMPLE_RISE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs,
  input  logic             spi_clk,
  input  logic             spi_data,
  input  logic             rx_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy,
  output logic [4:0]       bit_count
);

  localparam logic [4:0] WIDTH_CNT = 5'(WIDTH);

  logic             cs_meta_r;
  logic             clk_meta_r;
  logic             data_meta_r;
  logic             s_cs;
  logic             s_clk;
  logic             s_data;
  logic             s_clk_d_r;
  logic             s_cs_d_r;
  logic [WIDTH-1:0] shift_r;

  logic             rise_s;
  logic             fall_s;
  logic             qual_edge_s;
  logic             cs_rise_s;
  logic [4:0]       count_inc_s;
  logic [WIDTH-1:0] word_s;
  logic             word_done_s;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [4:0]       count_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;
  logic             valid_nxt_s;
  logic             ovr_event_s;
  logic             ovr_nxt_s;
  logic             ferr_nxt_s;
  logic             busy_nxt_s;

  // Two-flop synchronizers plus one-cycle delayed copies for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_meta_r   <= 1'b1;
      s_cs        <= 1'b1;
      clk_meta_r  <= 1'b0;
      s_clk       <= 1'b0;
      data_meta_r <= 1'b0;
      s_data      <= 1'b0;
      s_clk_d_r   <= 1'b0;
      s_cs_d_r    <= 1'b1;
    end else begin
      cs_meta_r   <= spi_cs;
      s_cs        <= cs_meta_r;
      clk_meta_r  <= spi_clk;
      s_clk       <= clk_meta_r;
      data_meta_r <= spi_data;
      s_data      <= data_meta_r;
      s_clk_d_r   <= s_clk;
      s_cs_d_r    <= s_cs;
    end
  end

  assign rise_s      = s_clk & ~s_clk_d_r;
  assign fall_s      = ~s_clk & s_clk_d_r;
  assign qual_edge_s = (CPOL0_SAMPLE_RISE ? rise_s : fall_s) & ~s_cs;
  assign cs_rise_s   = s_cs & ~s_cs_d_r;
  assign count_inc_s = bit_count + 5'd1;
  assign word_s      = {shift_r[WIDTH-2:0], s_data};

  // Frame assembly: shift on qualified edges, restart on completion or chip-select release.
  always_comb begin
    shift_nxt_s = shift_r;
    count_nxt_s = bit_count;
    word_done_s = 1'b0;
    if (cs_rise_s) begin
      shift_nxt_s = '0;
      count_nxt_s = 5'd0;
    end else if (qual_edge_s) begin
      if (count_inc_s == WIDTH_CNT) begin
        word_done_s = 1'b1;
        shift_nxt_s = '0;
        count_nxt_s = 5'd0;
      end else begin
        shift_nxt_s = word_s;
        count_nxt_s = count_inc_s;
      end
    end else begin
      shift_nxt_s = shift_r;
      count_nxt_s = bit_count;
    end
  end

  // Output handshake: a completed word is dropped only if the held word is not being taken.
  always_comb begin
    data_nxt_s  = rx_data;
    valid_nxt_s = rx_valid;
    ovr_event_s = 1'b0;
    if (word_done_s) begin
      if (rx_valid && !rx_ready) begin
        ovr_event_s = 1'b1;
      end else begin
        data_nxt_s  = word_s;
        valid_nxt_s = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = rx_valid;
    end

    if (ovr_event_s) begin
      ovr_nxt_s = 1'b1;
    end else if (overrun_clr) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = overrun;
    end

    ferr_nxt_s = cs_rise_s & (bit_count != 5'd0);
    busy_nxt_s = (count_nxt_s != 5'd0);
  end

  // Frame and output state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r   <= '0;
      bit_count <= 5'd0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      shift_r   <= shift_nxt_s;
      bit_count <= count_nxt_s;
      rx_data   <= data_nxt_s;
      rx_valid  <= valid_nxt_s;
      overrun   <= ovr_nxt_s;
      frame_err <= ferr_nxt_s;
      busy      <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx (WIDTH=16, sample on rising spi_clk).
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_data = 1'b0;
  logic        rx_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        overrun;
  logic        frame_err;
  logic        busy;
  logic [4:0]  bit_count;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt = 0;
  int fcnt = 0;
  logic [15:0] last_data = 16'h0000;
  int vbase;
  int fbase;

  spi_slave_rx #(.WIDTH(16), .CPOL0_SAMPLE_RISE(1'b1)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_data(spi_data), .rx_ready(rx_ready), .overrun_clr(overrun_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .busy(busy), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  // Count valid cycles and frame_err pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt = vcnt + 1;
      last_data = rx_data;
    end
    if (frame_err) fcnt = fcnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One spi_clk period, 4 clk low (data setup) then 4 clk high; optional ready strobe
  // placed in the cycle the synchronized rising edge is seen.
  task automatic send_bit(input logic b, input bit strobe);
    spi_data = b;
    repeat (4) @(posedge clk);
    #1 spi_clk = 1'b1;
    if (strobe) begin
      repeat (2) @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      repeat (4) @(posedge clk);
      #1;
    end
    spi_clk = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits, input bit strobe_last);
    for (int i = 0; i < nbits; i++) send_bit(w[15-i], strobe_last && (i == nbits - 1));
  endtask

  task automatic settle;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rx_data", 32'(rx_data), 32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_bit_count", 32'(bit_count), 32'h0);
    reset = 1'b0;
    settle();

    // Single frame with consumer always ready
    vbase = vcnt; fbase = fcnt;
    rx_ready = 1'b1;
    spi_cs = 1'b0;
    settle();
    send_word(16'hA5C3, 16, 1'b0);
    settle();
    spi_cs = 1'b1;
    settle();
    check_eq("a5c3_valid_cycles", 32'(vcnt - vbase), 32'd1);
    check_eq("a5c3_data", 32'(last_data), 32'hA5C3);
    check_eq("a5c3_overrun", 32'(overrun), 32'h0);
    check_eq("a5c3_frame_err", 32'(fcnt - fbase), 32'd0);
    check_eq("a5c3_bit_count", 32'(bit_count), 32'd0);
    rx_ready = 1'b0;

    // Back-to-back frames with no consumer: second word is dropped
    spi_cs = 1'b0;
    settle();
    send_word(16'h1234, 16, 1'b0);
    send_word(16'hBEEF, 16, 1'b0);
    settle();
    check_eq("b2b_valid", 32'(rx_valid), 32'h1);
    check_eq("b2b_data", 32'(rx_data), 32'h1234);
    check_eq("b2b_overrun", 32'(overrun), 32'h1);
    overrun_clr = 1'b1;
    @(posedge clk);
    #1 overrun_clr = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ovr_clr", 32'(overrun), 32'h0);
    check_eq("ovr_clr_valid_held", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("b2b_consumed", 32'(rx_valid), 32'h0);
    spi_cs = 1'b1;
    settle();

    // Chip select released after 7 bits
    vbase = vcnt; fbase = fcnt;
    spi_cs = 1'b0;
    settle();
    send_word(16'hFFFF, 7, 1'b0);
    settle();
    check_eq("partial_bit_count", 32'(bit_count), 32'd7);
    check_eq("partial_busy", 32'(busy), 32'h1);
    spi_cs = 1'b1;
    settle();
    check_eq("ferr_pulses", 32'(fcnt - fbase), 32'd1);
    check_eq("ferr_bit_count", 32'(bit_count), 32'd0);
    check_eq("ferr_busy", 32'(busy), 32'h0);
    check_eq("ferr_no_valid", 32'(vcnt - vbase), 32'd0);
    vbase = vcnt;
    rx_ready = 1'b1;
    spi_cs = 1'b0;
    settle();
    send_word(16'h0001, 16, 1'b0);
    settle();
    check_eq("after_ferr_cycles", 32'(vcnt - vbase), 32'd1);
    check_eq("after_ferr_data", 32'(last_data), 32'h0001);
    rx_ready = 1'b0;
    spi_cs = 1'b1;
    settle();

    // spi_clk toggled with chip select inactive
    vbase = vcnt; fbase = fcnt;
    send_word(16'h5A5A, 16, 1'b0);
    settle();
    check_eq("cs_high_bit_count", 32'(bit_count), 32'd0);
    check_eq("cs_high_no_valid", 32'(vcnt - vbase), 32'd0);
    check_eq("cs_high_no_ferr", 32'(fcnt - fbase), 32'd0);

    // Acceptance coinciding with completion of the next word
    spi_cs = 1'b0;
    settle();
    send_word(16'h1111, 16, 1'b0);
    settle();
    check_eq("pre_coincide_data", 32'(rx_data), 32'h1111);
    send_word(16'h00FF, 16, 1'b1);
    settle();
    check_eq("coincide_valid", 32'(rx_valid), 32'h1);
    check_eq("coincide_data", 32'(rx_data), 32'h00FF);
    check_eq("coincide_overrun", 32'(overrun), 32'h0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    spi_cs = 1'b1;
    settle();

    // Reset mid-frame, then a clean frame
    fbase = fcnt;
    spi_cs = 1'b0;
    settle();
    send_word(16'hFFFF, 9, 1'b0);
    settle();
    check_eq("pre_reset_bit_count", 32'(bit_count), 32'd9);
    reset = 1'b1;
    #2;
    check_eq("async_reset_bit_count", 32'(bit_count), 32'd0);
    check_eq("async_reset_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    vbase = vcnt;
    rx_ready = 1'b1;
    send_word(16'h8001, 16, 1'b0);
    settle();
    spi_cs = 1'b1;
    settle();
    check_eq("post_reset_cycles", 32'(vcnt - vbase), 32'd1);
    check_eq("post_reset_data", 32'(last_data), 32'h8001);
    check_eq("post_reset_no_ferr", 32'(fcnt - fbase), 32'd0);
    rx_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the frame length in bits (range 2..31).
REQ-002 The block SHALL have parameter CPOL0_SAMPLE_RISE, default 1; value 1 means data is sampled on the rising edge of spi_clk.
REQ-003 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 spi_cs  input  1  chip select from the master, active low, asynchronous to clk.
REQ-006 spi_clk  input  1  serial clock from the master, asynchronous to clk.
REQ-007 spi_data  input  1  serial data from the master (MOSI), MSB first.
REQ-008 rx_ready  input  1  consumer accepts rx_data when high while rx_valid is high.
REQ-009 overrun_clr  input  1  single-cycle pulse that clears overrun.
REQ-010 rx_data  output  WIDTH  last complete received word.
REQ-011 rx_valid  output  1  rx_data holds an unaccepted word.
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.
REQ-013 frame_err  output  1  one-cycle pulse: spi_cs deasserted mid-frame.
REQ-014 busy  output  1  a frame is in progress (at least one bit received, frame incomplete).
REQ-015 bit_count  output  5  number of bits received in the current frame.

Function
REQ-016 spi_cs, spi_clk and spi_data SHALL each pass through a two-flop synchronizer (s_cs, s_clk, s_data) before use.
REQ-017 A qualified edge SHALL be detected when s_clk is 1 and its one-cycle-delayed copy is 0 (rising; falling if CPOL0_SAMPLE_RISE=0) while s_cs is 0.
REQ-018 Edges with s_cs at 1 SHALL be ignored and SHALL not change any state.
REQ-019 On each qualified edge the shift register SHALL shift left, inserting s_data at bit 0, and bit_count SHALL increment by 1.
REQ-020 On the qualified edge that makes bit_count equal WIDTH, the shift value including the new bit SHALL be the completed word and bit_count SHALL return to 0 on the next clock.
REQ-021 A completed word SHALL appear on rx_data with rx_valid high on the clock edge following the completing qualified-edge cycle.
REQ-022 rx_valid and rx_data SHALL hold stable until a cycle with rx_valid=1 and rx_ready=1; rx_valid SHALL drop on the following edge.
REQ-023 If a word completes while rx_valid=1 and rx_ready=0, the new word SHALL be discarded, rx_data SHALL keep the old word and overrun SHALL set.
REQ-024 If a word completes in the same cycle as acceptance (rx_valid=1, rx_ready=1), the new word SHALL be loaded, rx_valid SHALL stay 1 and overrun SHALL not set.
REQ-025 overrun SHALL remain 1 until overrun_clr; if overrun_clr coincides with a new overrun event, overrun SHALL remain 1.
REQ-026 A rising s_cs with bit_count between 1 and WIDTH-1 SHALL pulse frame_err for exactly one cycle, clear bit_count and the shift register, and leave rx_data/rx_valid unchanged.
REQ-027 A rising s_cs with bit_count 0 SHALL not pulse frame_err.
REQ-028 busy SHALL equal (bit_count != 0).
REQ-029 Back-to-back frames with spi_cs held low SHALL be received without gap; bit WIDTH+1 starts a new frame.
REQ-030 Minimum supported spi_clk high and low times SHALL each be 3 clk periods; shorter pulses are out of specification.

Reset
REQ-031 While reset is high, all synchronizer flops SHALL be at their idle value (s_cs=1, s_clk=0, s_data=0), and rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, bit_count=0, shift register 0, independent of clk.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the first qualified edge after reset release SHALL be counted as bit 1.

Verification
REQ-033 Reset then frame 16'hA5C3 with spi_cs low, rx_ready=1 -> one rx_valid cycle, rx_data=16'hA5C3, overrun=0, frame_err=0.
REQ-034 Two frames 16'h1234, 16'hBEEF back-to-back, rx_ready=0 -> rx_data=16'h1234 held, rx_valid=1, overrun=1 after the second frame; overrun_clr -> overrun=0.
REQ-035 spi_cs deasserted after 7 bits of 16'hFFFF -> frame_err pulses once, bit_count=0, rx_valid stays 0; next full frame 16'h0001 received correctly.
REQ-036 spi_clk toggled 16 times with spi_cs high -> no rx_valid, bit_count stays 0.
REQ-037 rx_ready raised in the exact cycle a second word 16'h00FF completes -> rx_valid stays 1, rx_data=16'h00FF, overrun=0.
REQ-038 reset pulsed after 9 bits, then a full frame 16'h8001 -> rx_data=16'h8001, no frame_err.
